inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 100 ++++++++++
 tb/tb_inst_fetch.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC register, registered chip enable and a
// 2-entry fetch buffer toward decode with branch redirect.
// Ports: clk, rst (sync, active-high); ce/inst_addr/inst to imem;
// branch_flag_i/branch_target_address_i redirect;
// id_valid_o/id_ready_i/id_pc_o/id_inst_o toward decode.
`ifndef ChipEnable
`define ChipEnable 1'b1
`endif
`ifndef ChipDisable
`define ChipDisable 1'b0
`endif
`ifndef InstAddrBus
`define InstAddrBus 31:0
`endif
`ifndef InstBus
`define InstBus 31:0
`endif

module inst_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  output logic                ce,
  output logic [`InstAddrBus] inst_addr,
  input  logic [`InstBus]     inst,
  input  logic                branch_flag_i,
  input  logic [`InstAddrBus] branch_target_address_i,
  output logic                id_valid_o,
  input  logic                id_ready_i,
  output logic [`InstAddrBus] id_pc_o,
  output logic [`InstBus]     id_inst_o
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FETCH = 1'b1;
  localparam logic [1:0] FULL  = 2'(BUF_DEPTH);

  logic [0:0]  state;
  logic [31:0] pc;
  logic [1:0]  count;
  logic        rd_ptr;
  logic        wr_ptr;
  logic [31:0] buf_pc   [2];
  logic [31:0] buf_inst [2];

  logic is_fetch;
  logic pop;
  logic push;

  assign is_fetch = (state == FETCH);
  assign pop      = id_valid_o & id_ready_i;
  // A free slot appears either from spare room or from a same-cycle pop.
  assign push     = is_fetch & ~branch_flag_i &
                    ((count < FULL) | pop);

  assign inst_addr  = pc;
  assign id_valid_o = (count != 2'd0);
  assign id_pc_o    = id_valid_o ? buf_pc[rd_ptr]   : '0;
  assign id_inst_o  = id_valid_o ? buf_inst[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ce     <= `ChipDisable;
      pc     <= {RESET_PC[31:2], 2'b00};
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      state <= FETCH;
      ce    <= `ChipEnable;
      if (branch_flag_i) begin
        // Redirect drops everything buffered, including a head being popped.
        pc     <= {branch_target_address_i[31:2], 2'b00};
        count  <= 2'd0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (push) begin
          pc     <= pc + 32'd4;
          wr_ptr <= ~wr_ptr;
        end
        if (pop) begin
          rd_ptr <= ~rd_ptr;
        end
        count <= count + 2'(push) - 2'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_ptr]   <= pc;
      buf_inst[wr_ptr] <= inst;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus a
// randomized ready stream checked against a sequential-PC model.
module tb_inst_fetch;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce;
  logic [31:0] inst_addr;
  logic [31:0] inst;
  logic        br = 1'b0;
  logic [31:0] tgt = '0;
  logic        valid;
  logic        ready = 1'b0;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  logic        rst2 = 1'b1;
  logic        ce2;
  logic [31:0] inst_addr2;
  logic [31:0] inst2;
  logic        valid2;
  logic [31:0] id_pc2;
  logic [31:0] id_inst2;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  assign inst  = inst_addr ^ KEY;
  assign inst2 = inst_addr2 ^ KEY;

  inst_fetch dut (
    .clk(clk), .rst(rst), .ce(ce),
    .inst_addr(inst_addr), .inst(inst),
    .branch_flag_i(br),
    .branch_target_address_i(tgt),
    .id_valid_o(valid), .id_ready_i(ready),
    .id_pc_o(id_pc), .id_inst_o(id_inst)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst2), .ce(ce2),
    .inst_addr(inst_addr2), .inst(inst2),
    .branch_flag_i(1'b0),
    .branch_target_address_i(32'h0),
    .id_valid_o(valid2), .id_ready_i(1'b1),
    .id_pc_o(id_pc2), .id_inst_o(id_inst2)
  );

  // Returns at the negedge after the reset edge; the next edge
  // moves IDLE -> FETCH.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; br = 1'b0; ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total_cnt++;
    if (ce !== 1'b0) $display("FAIL rst_ce got %b want 0", ce);
    else pass_cnt++;
    total_cnt++;
    if (valid !== 1'b0) $display("FAIL rst_valid got %b want 0", valid);
    else pass_cnt++;
    total_cnt++;
    if (inst_addr !== 32'h0)
      $display("FAIL rst_addr got %h want 0", inst_addr);
    else pass_cnt++;
    total_cnt++;
    if (id_pc !== 32'h0 || id_inst !== 32'h0)
      $display("FAIL rst_head got %h/%h want 0/0", id_pc, id_inst);
    else pass_cnt++;
  endtask

  task automatic test_sequential();
    logic [31:0] e;
    rst = 1'b0; ready = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (ce !== 1'b1 || valid !== 1'b0 || inst_addr !== 32'h0)
      $display("FAIL seq_first got ce=%b v=%b a=%h want 1/0/0",
               ce, valid, inst_addr);
    else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      e = 32'(4 * i);
      total_cnt++;
      if (valid !== 1'b1 || id_pc !== e || id_inst !== (e ^ KEY))
        $display("FAIL seq_%0d got v=%b pc=%h i=%h want 1/%h/%h",
                 i, valid, id_pc, id_inst, e, e ^ KEY);
      else pass_cnt++;
    end
  endtask

  task automatic test_stall();
    logic [31:0] e;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if (valid !== 1'b1 || id_pc !== 32'h0)
        $display("FAIL stall_head_%0d got v=%b pc=%h want 1/0",
                 i, valid, id_pc);
      else pass_cnt++;
      if (i > 0) begin
        total_cnt++;
        if (inst_addr !== 32'h8)
          $display("FAIL stall_addr_%0d got %h want 8", i, inst_addr);
        else pass_cnt++;
      end
      @(negedge clk);
    end
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e = 32'(4 * i);
      total_cnt++;
      if (valid !== 1'b1 || id_pc !== e || id_inst !== (e ^ KEY))
        $display("FAIL drain_%0d got v=%b pc=%h want 1/%h",
                 i, valid, id_pc, e);
      else pass_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    do_reset();
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ready = 1'b0;
    total_cnt++;
    if (id_pc !== 32'h8 || inst_addr !== 32'h10)
      $display("FAIL br_setup got pc=%h a=%h want 8/10", id_pc, inst_addr);
    else pass_cnt++;
    br = 1'b1; tgt = 32'h0000_0103;
    @(negedge clk);
    br = 1'b0; ready = 1'b1;
    total_cnt++;
    if (valid !== 1'b0 || inst_addr !== 32'h100)
      $display("FAIL br_flush got v=%b a=%h want 0/100", valid, inst_addr);
    else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total_cnt++;
      if (valid !== 1'b1 || id_pc !== 32'(32'h100 + 4 * i))
        $display("FAIL br_tgt_%0d got v=%b pc=%h want 1/%h",
                 i, valid, id_pc, 32'h100 + 4 * i);
      else pass_cnt++;
    end
  endtask

  task automatic test_idle_branch();
    @(negedge clk);
    rst = 1'b1; ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; br = 1'b1; tgt = 32'h0000_0202;
    @(negedge clk);
    br = 1'b0;
    total_cnt++;
    if (ce !== 1'b1 || inst_addr !== 32'h200)
      $display("FAIL idle_br got ce=%b a=%h want 1/200", ce, inst_addr);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (valid !== 1'b1 || id_pc !== 32'h200)
      $display("FAIL idle_br_head got v=%b pc=%h want 1/200", valid, id_pc);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; ready = 1'b1;
    total_cnt++;
    if (valid !== 1'b0 || ce !== 1'b0 || inst_addr !== 32'h0)
      $display("FAIL rmid got v=%b ce=%b a=%h want 0/0/0",
               valid, ce, inst_addr);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (ce !== 1'b1 || valid !== 1'b0)
      $display("FAIL rmid_restart got ce=%b v=%b want 1/0", ce, valid);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (valid !== 1'b1 || id_pc !== 32'h0)
      $display("FAIL rmid_head got v=%b pc=%h want 1/0", valid, id_pc);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [31:0] e;
    @(negedge clk);
    rst2 = 1'b0;
    @(negedge clk);
    e = 32'hFFFF_FFF8;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total_cnt++;
      if (valid2 !== 1'b1 || id_pc2 !== e || id_inst2 !== (e ^ KEY))
        $display("FAIL wrap_%0d got v=%b pc=%h want 1/%h",
                 i, valid2, id_pc2, e);
      else pass_cnt++;
      e = e + 32'd4;
    end
  endtask

  task automatic test_random();
    logic [31:0] e;
    logic [31:0] held;
    logic        hold;
    int          pops;
    e = 32'h0; hold = 1'b0; held = '0; pops = 0;
    do_reset();
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (hold) begin
        total_cnt++;
        if (valid !== 1'b1 || id_pc !== held)
          $display("FAIL rnd_hold c=%0d got v=%b pc=%h want 1/%h",
                   c, valid, id_pc, held);
        else pass_cnt++;
      end
      ready = 1'($urandom_range(0, 1));
      if (valid === 1'b1 && ready) begin
        total_cnt++;
        if (id_pc !== e || id_inst !== (e ^ KEY))
          $display("FAIL rnd_pop c=%0d got pc=%h i=%h want %h/%h",
                   c, id_pc, id_inst, e, e ^ KEY);
        else pass_cnt++;
        e = e + 32'd4;
        pops++;
      end
      hold = (valid === 1'b1) && !ready;
      held = id_pc;
    end
    total_cnt++;
    if (pops < 300)
      $display("FAIL rnd_progress got %0d pops want >=300", pops);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_idle_branch();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
